// File: rtl/ps2_data_in_receiver.sv
// ps2_data_in_receiver: device-to-host half of the PS/2 core.
// Deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop)
// using the synchronised PS2_CLK edge pulses shared with the command
// transmitter. A good byte is delivered with a one-cycle received_data_en
// strobe. A bad stop bit or an inter-edge timeout gives a one-cycle
// frame_error strobe.
//
// Optional build macro PS2_RX_PARITY_CHECK_EN: when defined, a parity
// mismatch also raises frame_error and drops the byte. When undefined, the
// parity bit still takes up its slot in the frame but its value is ignored.
//
// Handshake: received_data_en and frame_error are single-cycle strobes with no
// back-pressure. They are mutually exclusive, and received_data is valid in
// the strobe cycle and holds until the next good frame.
module ps2_data_in_receiver #(
    parameter int TIMEOUT_CYCLES       = 100000,
    parameter int TIMEOUT_COUNTER_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_data,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       frame_error,
    output logic       rx_busy,
    output logic [2:0] rx_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DATA      = 3'd1;
    localparam logic [2:0] S_PARITY    = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [2:0]                      state;
    logic [2:0]                      bit_count;
    logic [7:0]                      shift_reg;
    logic [TIMEOUT_COUNTER_BITS-1:0] timer;
    logic [TIMEOUT_COUNTER_BITS-1:0] timer_inc;
    logic                            in_frame;
    logic                            timeout;
    logic                            frame_good;

`ifdef PS2_RX_PARITY_CHECK_EN
    logic parity_bit;
    logic parity_ok;
    assign parity_ok  = ^{shift_reg, parity_bit};
    assign frame_good = ps2_data && parity_ok;
`else
    assign frame_good = ps2_data;
`endif

    // The timer runs only while a frame is in progress.
    assign in_frame  = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
    assign timer_inc = timer + 1'b1;
    // The timeout fires on the edge where the timer reaches TIMEOUT_CYCLES.
    // The error strobe is therefore visible TIMEOUT_CYCLES cycles after the
    // last negedge. A negedge in that same cycle takes priority.
    assign timeout   = in_frame && !ps2_clk_negedge &&
                       (timer_inc == TIMEOUT_COUNTER_BITS'(TIMEOUT_CYCLES));

    assign rx_busy  = (state != S_IDLE);
    assign rx_state = state;

    // Frame FSM, bit sampling, inter-edge timer and output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            bit_count        <= 3'd0;
            shift_reg        <= 8'h00;
            timer            <= '0;
            received_data    <= 8'h00;
            received_data_en <= 1'b0;
            frame_error      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            parity_bit       <= 1'b0;
`endif
        end else begin
            received_data_en <= 1'b0;
            frame_error      <= 1'b0;

            if (!in_frame || ps2_clk_negedge)
                timer <= '0;
            else
                timer <= timer_inc;

            if (state != S_DATA)
                bit_count <= 3'd0;

            if (state != S_IDLE && !rx_enable) begin
                // Command transmission is taking the bus, so drop the frame silently.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_enable && ps2_clk_negedge && !ps2_data)
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        if (ps2_clk_negedge) begin
                            shift_reg[bit_count] <= ps2_data;
                            bit_count            <= bit_count + 3'd1;
                            if (bit_count == 3'd7)
                                state <= S_PARITY;
                        end else if (timeout) begin
                            frame_error <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    S_PARITY: begin
                        if (ps2_clk_negedge) begin
`ifdef PS2_RX_PARITY_CHECK_EN
                            parity_bit <= ps2_data;
`endif
                            state <= S_STOP;
                        end else if (timeout) begin
                            frame_error <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    S_STOP: begin
                        if (ps2_clk_negedge) begin
                            if (frame_good) begin
                                received_data    <= shift_reg;
                                received_data_en <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                            state <= S_WAIT_HIGH;
                        end else if (timeout) begin
                            frame_error <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    S_WAIT_HIGH: begin
                        // Wait for the clock to rise so the stop-bit negedge is not taken as a start bit.
                        if (ps2_clk_posedge)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_data_in_receiver.sv
// Testbench for ps2_data_in_receiver. Frames are built from their data byte,
// parity and stop choices. Each frame's expected outcome (a byte or an error)
// is queued. A monitor pops the queue whenever the DUT strobes.
module tb_ps2_data_in_receiver;

    localparam int T = 200;
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_enable;
    logic       neg;
    logic       pos;
    logic       dat;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       frame_error;
    logic       rx_busy;
    logic [2:0] rx_state;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_last;
    logic [8:0] mon_e;

    ps2_data_in_receiver #(
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_COUNTER_BITS(17)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_enable(rx_enable),
        .ps2_clk_negedge(neg),
        .ps2_clk_posedge(pos),
        .ps2_data(dat),
        .received_data(received_data),
        .received_data_en(received_data_en),
        .frame_error(frame_error),
        .rx_busy(rx_busy),
        .rx_state(rx_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued outcome.
    always @(negedge clk) begin
        if (received_data_en || frame_error) begin
            if (received_data_en && frame_error)
                check("strobes_exclusive", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, received_data_en, frame_error}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("scoreboard", frame_error ? 32'h100 : {24'd0, received_data}, {23'd0, mon_e});
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one PS/2 clock period: a posedge pulse mid-gap, then a negedge carrying bit d.
    task automatic ps2_fall(input logic d);
        int g;
        g = $urandom_range(4, 12);
        idle_cycles(g / 2);
        pos = 1'b1;
        @(negedge clk);
        pos = 1'b0;
        idle_cycles(g - g / 2);
        dat = d;
        neg = 1'b1;
        @(negedge clk);
        neg = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_good, input logic stop);
        logic p;
        logic good;
        p    = par_good ? ~^d : ^d;
        good = stop && (par_good || !PCHK);
        ps2_fall(1'b0);
        for (int i = 0; i < 8; i++) ps2_fall(d[i]);
        ps2_fall(p);
        exp_q.push_back(good ? {1'b0, d} : 9'h100);
        if (good) exp_last = d;
        ps2_fall(stop);
        check("en_latency", received_data_en, good);
        check("err_latency", frame_error, !good);
        @(negedge clk);
        check("strobe_one_cycle", {received_data_en, frame_error}, 2'b00);
        check("busy_wait_high", rx_busy, 1'b1);
        check("held_data", received_data, exp_last);
        pos = 1'b1;
        @(negedge clk);
        pos = 1'b0;
        check("busy_after_posedge", rx_busy, 1'b0);
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int seen;
        reset = 1'b1; rx_enable = 1'b1; neg = 1'b0; pos = 1'b0; dat = 1'b1;
        exp_last = 8'h00;
        idle_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data", received_data, 8'h00);
        check("reset_strobes", {received_data_en, frame_error}, 2'b00);
        check("reset_busy", rx_busy, 1'b0);
        check("reset_state", rx_state, 3'd0);

        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b0);

        // Stall after 4 data bits.
        ps2_fall(1'b0);
        for (int i = 0; i < 4; i++) ps2_fall(8'h1C >> i);
        exp_q.push_back(9'h100);
        seen = 0;
        for (int i = 1; i <= T + 10; i++) begin
            @(negedge clk);
            if (frame_error) begin
                seen = i;
                break;
            end
        end
        check("timeout_latency", seen, T);
        check("timeout_state", rx_state, 3'd0);
        check("timeout_busy", rx_busy, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1);

        // rx_enable dropped mid-frame.
        ps2_fall(1'b0);
        for (int i = 0; i < 4; i++) ps2_fall(1'b1);
        check("busy_mid_frame", rx_busy, 1'b1);
        rx_enable = 1'b0;
        @(negedge clk);
        check("abort_busy", rx_busy, 1'b0);
        check("abort_state", rx_state, 3'd0);
        check("abort_data", received_data, exp_last);
        rx_enable = 1'b1;
        idle_cycles(3);

        // Reset mid-frame.
        ps2_fall(1'b0);
        for (int i = 0; i < 3; i++) ps2_fall(1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_last = 8'h00;
        check("midreset_busy", rx_busy, 1'b0);
        check("midreset_data", received_data, 8'h00);
        check("midreset_strobes", {received_data_en, frame_error}, 2'b00);
        idle_cycles(3);

        // Randomised frames.
        for (int k = 0; k < 24; k++)
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));

        idle_cycles(10);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
